axi_read_reorder: RTL and testbench

AXI_READ_REORDER -- requirements
Module: axi_read_reorder

---
 rtl/axi_read_reorder.sv | 135 +++++++++++++
 tb/tb_axi_read_reorder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_reorder.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_reorder
// Purpose  : Restores AR issue order on R responses returned out of order by
//            a downstream AXI slave, using a circular slot buffer.
// Revision : 1.0
// ============================================================================
module axi_read_reorder #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 16,
  parameter int RESP_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // slave-side AR
  input  logic [ID_WIDTH-1:0]          s_arid_i,
  input  logic                         s_arvalid_i,
  output logic                         s_arready_o,
  // slave-side R
  output logic [DATA_WIDTH-1:0]        s_rdata_o,
  output logic [ID_WIDTH-1:0]          s_rid_o,
  output logic [RESP_WIDTH-1:0]        s_rresp_o,
  output logic                         s_rvalid_o,
  input  logic                         s_rready_i,
  // master-side AR
  output logic [ID_WIDTH-1:0]          m_arid_o,
  output logic                         m_arvalid_o,
  input  logic                         m_arready_i,
  // master-side R
  input  logic [DATA_WIDTH-1:0]        m_rdata_i,
  input  logic [ID_WIDTH-1:0]          m_rid_i,
  input  logic [RESP_WIDTH-1:0]        m_rresp_i,
  input  logic                         m_rvalid_i,
  output logic                         m_rready_o,
  // status
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic                         unmatched_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [OCC_W-1:0] C_FULL = OCC_W'(DEPTH);

  logic [DEPTH-1:0]       r_valid;
  logic [DEPTH-1:0]       r_filled;
  logic [ID_WIDTH-1:0]    r_id   [DEPTH];
  logic [DATA_WIDTH-1:0]  r_data [DEPTH];
  logic [RESP_WIDTH-1:0]  r_resp [DEPTH];

  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [OCC_W-1:0]       r_occ;
  logic                   r_unmatched;

  logic                   w_full;
  logic                   w_alloc;
  logic                   w_mr_hs;
  logic                   w_drain;
  logic                   w_match;
  logic [PTR_W-1:0]       w_match_idx;
  logic [PTR_W-1:0]       w_scan;

  // Full comes from registered occupancy, so a same-cycle drain never frees AR.
  assign w_full      = (r_occ == C_FULL);
  assign m_arvalid_o = s_arvalid_i & ~w_full;
  assign s_arready_o = m_arready_i & ~w_full;
  assign m_arid_o    = s_arid_i;
  assign m_rready_o  = rst_n;

  assign w_alloc = s_arvalid_i & s_arready_o;
  assign w_mr_hs = m_rvalid_i & m_rready_o;

  assign s_rvalid_o  = r_valid[r_head] & r_filled[r_head];
  assign s_rdata_o   = r_data[r_head];
  assign s_rid_o     = r_id[r_head];
  assign s_rresp_o   = r_resp[r_head];
  assign w_drain     = s_rvalid_o & s_rready_i;
  assign occupancy_o = r_occ;
  assign unmatched_o = r_unmatched;

  // Oldest-first search from head keeps same-ID responses in issue order.
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    w_scan      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan = r_head + PTR_W'(k);
      if (!w_match && r_valid[w_scan] && !r_filled[w_scan] && (r_id[w_scan] == m_rid_i)) begin
        w_match     = 1'b1;
        w_match_idx = w_scan;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid     <= '0;
      r_filled    <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_occ       <= '0;
      r_unmatched <= 1'b0;
    end else begin
      if (w_alloc) begin
        r_valid[r_tail]  <= 1'b1;
        r_filled[r_tail] <= 1'b0;
        r_tail           <= r_tail + 1'b1;
      end
      if (w_mr_hs && w_match) begin
        r_filled[w_match_idx] <= 1'b1;
      end
      if (w_drain) begin
        r_valid[r_head]  <= 1'b0;
        r_filled[r_head] <= 1'b0;
        r_head           <= r_head + 1'b1;
      end
      r_occ       <= r_occ + OCC_W'(w_alloc) - OCC_W'(w_drain);
      r_unmatched <= w_mr_hs & ~w_match;
    end
  end

  // Payload storage carries no reset; validity bits alone qualify it.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_id[r_tail] <= s_arid_i;
    end
    if (w_mr_hs && w_match) begin
      r_data[w_match_idx] <= m_rdata_i;
      r_resp[w_match_idx] <= m_rresp_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_read_reorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_read_reorder
// Purpose  : Directed self-checking bench for axi_read_reorder.
// Revision : 1.0
// ============================================================================
module tb_axi_read_reorder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] s_arid_i;
  logic       s_arvalid_i;
  logic       s_arready_o;
  logic [7:0] s_rdata_o;
  logic [3:0] s_rid_o;
  logic [1:0] s_rresp_o;
  logic       s_rvalid_o;
  logic       s_rready_i;
  logic [3:0] m_arid_o;
  logic       m_arvalid_o;
  logic       m_arready_i;
  logic [7:0] m_rdata_i;
  logic [3:0] m_rid_i;
  logic [1:0] m_rresp_i;
  logic       m_rvalid_i;
  logic       m_rready_o;
  logic [4:0] occupancy_o;
  logic       unmatched_o;

  int total = 0;
  int bad   = 0;

  axi_read_reorder #(.DATA_WIDTH(8), .ID_WIDTH(4), .DEPTH(16), .RESP_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arid_i(s_arid_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rdata_o(s_rdata_o), .s_rid_o(s_rid_o), .s_rresp_o(s_rresp_o),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .m_arid_o(m_arid_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rid_i(m_rid_i), .m_rresp_i(m_rresp_i),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .occupancy_o(occupancy_o), .unmatched_o(unmatched_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       arvalid;
    logic       marready;
    logic [3:0] arid;
    logic       exp_m_arvalid;
    logic       exp_s_arready;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ar(input logic [3:0] id);
    s_arvalid_i = 1'b1;
    s_arid_i    = id;
    step();
    s_arvalid_i = 1'b0;
  endtask

  task automatic mr(input logic [3:0] id, input logic [7:0] d, input logic [1:0] rs);
    m_rvalid_i = 1'b1;
    m_rid_i    = id;
    m_rdata_i  = d;
    m_rresp_i  = rs;
    step();
    m_rvalid_i = 1'b0;
  endtask

  task automatic expect_r(input string name, input logic [3:0] id, input logic [7:0] d, input logic [1:0] rs);
    int n;
    n = 0;
    while (!s_rvalid_o && n < 20) begin
      step();
      n++;
    end
    if (!s_rvalid_o) begin
      check({name, "_timeout"}, 32'(s_rvalid_o), 32'd1);
    end else begin
      check(name, {s_rid_o, s_rdata_o, s_rresp_o}, {id, d, rs});
      s_rready_i = 1'b1;
      step();
      s_rready_i = 1'b0;
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 4'h3, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 4'h6, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b0};

    rst_n = 1'b0; s_arid_i = '0; s_arvalid_i = 1'b0; s_rready_i = 1'b0;
    m_arready_i = 1'b1; m_rdata_i = '0; m_rid_i = '0; m_rresp_i = '0; m_rvalid_i = 1'b0;
    step(); step();
    check("rst_occ", 32'(occupancy_o), 32'd0);
    check("rst_rvalid", 32'(s_rvalid_o), 32'd0);
    check("rst_unmatched", 32'(unmatched_o), 32'd0);
    check("rst_mrready", 32'(m_rready_o), 32'd0);
    rst_n = 1'b1;
    step();
    check("mrready_up", 32'(m_rready_o), 32'd1);

    // AR pass-through, not full, no clock edge in between
    for (int i = 0; i < 4; i++) begin
      s_arvalid_i = tbl[i].arvalid;
      m_arready_i = tbl[i].marready;
      s_arid_i    = tbl[i].arid;
      #1;
      check($sformatf("ar_tbl%0d", i), {m_arvalid_o, s_arready_o, m_arid_o},
            {tbl[i].exp_m_arvalid, tbl[i].exp_s_arready, tbl[i].arid});
    end
    s_arvalid_i = 1'b0;
    m_arready_i = 1'b1;
    check("ar_tbl_occ", 32'(occupancy_o), 32'd0);

    // Out-of-order return
    ar(4'd0); ar(4'd1); ar(4'd2);
    check("ooo_occ", 32'(occupancy_o), 32'd3);
    mr(4'd2, 8'h22, 2'd0);
    check("ooo_head_wait", 32'(s_rvalid_o), 32'd0);
    mr(4'd0, 8'h00, 2'd0);
    mr(4'd1, 8'h11, 2'd0);
    expect_r("ooo_r0", 4'd0, 8'h00, 2'd0);
    expect_r("ooo_r1", 4'd1, 8'h11, 2'd0);
    expect_r("ooo_r2", 4'd2, 8'h22, 2'd0);
    check("ooo_occ_end", 32'(occupancy_o), 32'd0);

    // One-cycle latency
    ar(4'd3);
    mr(4'd3, 8'h33, 2'd1);
    check("lat1", {s_rvalid_o, s_rdata_o, s_rresp_o}, {1'b1, 8'h33, 2'd1});
    expect_r("lat1_r", 4'd3, 8'h33, 2'd1);

    // Same ID completes in issue order
    ar(4'd5); ar(4'd5);
    mr(4'd5, 8'hA1, 2'd0);
    mr(4'd5, 8'hA2, 2'd0);
    expect_r("same_r0", 4'd5, 8'hA1, 2'd0);
    expect_r("same_r1", 4'd5, 8'hA2, 2'd0);

    // Unmatched response
    mr(4'd7, 8'h77, 2'd0);
    check("unm_pulse", {unmatched_o, occupancy_o, s_rvalid_o}, {1'b1, 5'd0, 1'b0});
    step();
    check("unm_clear", 32'(unmatched_o), 32'd0);

    // A slot allocated this cycle is not yet matchable
    s_arvalid_i = 1'b1; s_arid_i = 4'd9;
    m_rvalid_i = 1'b1; m_rid_i = 4'd9; m_rdata_i = 8'h99; m_rresp_i = 2'd0;
    step();
    s_arvalid_i = 1'b0; m_rvalid_i = 1'b0;
    check("same_cyc", {unmatched_o, occupancy_o, s_rvalid_o}, {1'b1, 5'd1, 1'b0});
    mr(4'd9, 8'h9A, 2'd3);
    expect_r("same_cyc_r", 4'd9, 8'h9A, 2'd3);

    // Backpressure holds payload
    ar(4'd4);
    mr(4'd4, 8'h3C, 2'd2);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d", i), {s_rvalid_o, s_rid_o, s_rdata_o, s_rresp_o},
            {1'b1, 4'd4, 8'h3C, 2'd2});
      step();
    end
    s_rready_i = 1'b1;
    step();
    s_rready_i = 1'b0;
    check("hold_single", {s_rvalid_o, occupancy_o}, {1'b0, 5'd0});

    // Full boundary
    for (int i = 0; i < 16; i++) ar(4'(i));
    s_arvalid_i = 1'b1; s_arid_i = 4'd15;
    #1;
    check("full", {occupancy_o, s_arready_o, m_arvalid_o}, {5'd16, 1'b0, 1'b0});
    s_arvalid_i = 1'b0;
    mr(4'd0, 8'h50, 2'd0);
    s_arvalid_i = 1'b1; s_rready_i = 1'b1;
    #1;
    check("full_drain_same", 32'(s_arready_o), 32'd0);
    step();
    s_rready_i = 1'b0;
    check("full_after_drain", {occupancy_o, s_arready_o}, {5'd15, 1'b1});
    step();
    s_arvalid_i = 1'b0;
    check("full_again", 32'(occupancy_o), 32'd16);

    // Reset mid-operation
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    ar(4'd1); ar(4'd2); ar(4'd3); ar(4'd4);
    check("pre_rst_occ", 32'(occupancy_o), 32'd4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("post_rst", {occupancy_o, s_rvalid_o}, {5'd0, 1'b0});
    step();
    mr(4'd1, 8'h11, 2'd0);
    check("late_unm", {unmatched_o, s_rvalid_o, occupancy_o}, {1'b1, 1'b0, 5'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
